// File: rtl/sum_accum_pkg.sv
// Shared types and constants for the sum accumulator block.
// Optional build macro used by this block: SUM_ACCUMULATOR_SATURATE_EN.
package sum_accum_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int IN_W_DEF  = 5;
    localparam int ACC_W_DEF = 9;
    localparam int COUNT_DEF = 16;
    localparam int CNT_W     = 8;

endpackage

// File: rtl/sum_accumulator_if.sv
// Sample input and block-result output handshakes of the sum accumulator.
// master = producer/consumer side (bench or upstream), slave = accumulator.
interface sum_accumulator_if
    import sum_accum_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_sum;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, in_sum, flush, out_ready,
        input  in_ready, out_valid, out_acc, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_sum, flush, out_ready,
        output in_ready, out_valid, out_acc, out_cnt, out_ovf
    );
endinterface

// File: rtl/sum_accum_addsat.sv
// Combinational accumulate step: ACC_W+1-bit add of a zero-extended sample,
// carry-out detection, and (with SUM_ACCUMULATOR_SATURATE_EN) a clamp to the
// all-ones value on overflow. Without the macro the sum wraps.
module sum_accum_addsat
    import sum_accum_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc_in,
    input  logic [IN_W-1:0]  sample,
    output logic [ACC_W-1:0] sum_out,
    output logic             carry
);

    logic [ACC_W:0] wide_sum;

    // One extra bit of headroom so the carry out of the top bit is visible.
    always_comb begin
        wide_sum = {1'b0, acc_in} + (ACC_W+1)'(sample);
        carry    = wide_sum[ACC_W];
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        // Once clamped at max, any non-zero sample overflows again, so the
        // value stays pinned for the rest of the block.
        sum_out  = carry ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
        sum_out  = wide_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/sum_accumulator.sv
// Block accumulator for adder sums: accepts samples over a valid/ready port,
// sums up to COUNT of them (or fewer on flush) and presents the total, sample
// count and sticky overflow flag on a held valid/ready result port.
// Optional build macro: SUM_ACCUMULATOR_SATURATE_EN (clamp instead of wrap).
module sum_accumulator
    import sum_accum_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int COUNT = COUNT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    sum_accumulator_if.slave   bus
);

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ovf_reg, ovf_next;
    logic [ACC_W-1:0] out_acc_reg, out_acc_next;
    logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
    logic             out_ovf_reg, out_ovf_next;

    logic             accept;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic [CNT_W-1:0] cnt_inc;
    logic             close_block;

    sum_accum_addsat #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_addsat (
        .acc_in  (acc_reg),
        .sample  (bus.in_sum),
        .sum_out (add_sum),
        .carry   (add_carry)
    );

    // Handshake outputs are pure decodes of the state register.
    assign bus.in_ready  = (state_reg == ACCUM);
    assign bus.out_valid = (state_reg == HOLD);
    assign bus.out_acc   = out_acc_reg;
    assign bus.out_cnt   = out_cnt_reg;
    assign bus.out_ovf   = out_ovf_reg;

    assign accept      = bus.in_valid && (state_reg == ACCUM);
    assign cnt_inc     = cnt_reg + 1'b1;
    // A flush only closes a block that holds (or is about to hold) a sample.
    assign close_block = (accept && (cnt_inc == CNT_W'(COUNT)))
                       || (bus.flush && ((cnt_reg != '0) || accept));

    // Next-state and datapath updates; every target defaults to holding.
    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        cnt_next     = cnt_reg;
        ovf_next     = ovf_reg;
        out_acc_next = out_acc_reg;
        out_cnt_next = out_cnt_reg;
        out_ovf_next = out_ovf_reg;
        case (state_reg)
            ACCUM: begin
                if (accept) begin
                    acc_next = add_sum;
                    cnt_next = cnt_inc;
                    ovf_next = ovf_reg | add_carry;
                end
                if (close_block) begin
                    // Capture post-add values so a coincident sample is included.
                    state_next   = HOLD;
                    out_acc_next = acc_next;
                    out_cnt_next = cnt_next;
                    out_ovf_next = ovf_next;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_next = ACCUM;
                    acc_next   = '0;
                    cnt_next   = '0;
                    ovf_next   = 1'b0;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ACCUM;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            ovf_reg     <= 1'b0;
            out_acc_reg <= '0;
            out_cnt_reg <= '0;
            out_ovf_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            cnt_reg     <= cnt_next;
            ovf_reg     <= ovf_next;
            out_acc_reg <= out_acc_next;
            out_cnt_reg <= out_cnt_next;
            out_ovf_reg <= out_ovf_next;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default-sized instance (A) plus a
// narrow ACC_W=6 / COUNT=4 instance (B) for the overflow case.
module tb_sum_accumulator;
    import sum_accum_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    sum_accumulator_if #(.IN_W(5), .ACC_W(9)) bus_a ();
    sum_accumulator_if #(.IN_W(5), .ACC_W(6)) bus_b ();

    sum_accumulator #(.IN_W(5), .ACC_W(9), .COUNT(16)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    sum_accumulator #(.IN_W(5), .ACC_W(6), .COUNT(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [4:0] v);
        bus_a.in_valid = 1'b1;
        bus_a.in_sum   = v;
        tick();
        bus_a.in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [4:0] v);
        bus_b.in_valid = 1'b1;
        bus_b.in_sum   = v;
        tick();
        bus_b.in_valid = 1'b0;
    endtask

    initial begin
        bus_a.in_valid = 1'b0; bus_a.in_sum = '0; bus_a.flush = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0; bus_b.in_sum = '0; bus_b.flush = 1'b0; bus_b.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(bus_a.in_ready), 1);
        check("rst_out_valid", 32'(bus_a.out_valid), 0);
        check("rst_out_acc", 32'(bus_a.out_acc), 0);
        check("rst_out_cnt", 32'(bus_a.out_cnt), 0);
        check("rst_out_ovf", 32'(bus_a.out_ovf), 0);
        $display("txn: reset done");

        // Full block of 16 x 5
        for (int i = 0; i < 15; i++) send_a(5'd5);
        check("full_no_early_valid", 32'(bus_a.out_valid), 0);
        send_a(5'd5);
        check("full_valid", 32'(bus_a.out_valid), 1);
        check("full_in_ready_low", 32'(bus_a.in_ready), 0);
        check("full_acc", 32'(bus_a.out_acc), 80);
        check("full_cnt", 32'(bus_a.out_cnt), 16);
        check("full_ovf", 32'(bus_a.out_ovf), 0);
        tick();
        check("full_valid_one_cycle", 32'(bus_a.out_valid), 0);
        check("full_acc_kept", 32'(bus_a.out_acc), 80);
        $display("txn: full block 16x5 acc=%0d cnt=%0d", bus_a.out_acc, bus_a.out_cnt);

        // Partial block closed by idle flush
        send_a(5'd10);
        send_a(5'd20);
        send_a(5'd31);
        check("partial_no_valid", 32'(bus_a.out_valid), 0);
        bus_a.flush = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        check("flush_valid", 32'(bus_a.out_valid), 1);
        check("flush_acc", 32'(bus_a.out_acc), 61);
        check("flush_cnt", 32'(bus_a.out_cnt), 3);
        check("flush_ovf", 32'(bus_a.out_ovf), 0);
        tick();
        check("flush_emitted", 32'(bus_a.out_valid), 0);
        $display("txn: flush block acc=%0d cnt=%0d", bus_a.out_acc, bus_a.out_cnt);

        // Flush on an empty block is ignored
        bus_a.flush = 1'b1;
        tick();
        bus_a.flush = 1'b0;
        check("empty_flush_valid", 32'(bus_a.out_valid), 0);
        check("empty_flush_ready", 32'(bus_a.in_ready), 1);
        $display("txn: empty flush ignored");

        // Flush coincident with a sample includes the sample
        send_a(5'd7);
        send_a(5'd9);
        bus_a.flush = 1'b1;
        send_a(5'd4);
        bus_a.flush = 1'b0;
        check("coflush_valid", 32'(bus_a.out_valid), 1);
        check("coflush_acc", 32'(bus_a.out_acc), 20);
        check("coflush_cnt", 32'(bus_a.out_cnt), 3);
        tick();
        $display("txn: coincident flush acc=%0d cnt=%0d", bus_a.out_acc, bus_a.out_cnt);

        // Back-pressure: full block of 2s, out_ready low for 5 cycles
        bus_a.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) send_a(5'd2);
        check("bp_valid", 32'(bus_a.out_valid), 1);
        check("bp_acc", 32'(bus_a.out_acc), 32);
        bus_a.in_valid = 1'b1;
        bus_a.in_sum   = 5'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(bus_a.out_valid), 1);
            check("bp_hold_in_ready", 32'(bus_a.in_ready), 0);
            check("bp_hold_acc", 32'(bus_a.out_acc), 32);
            check("bp_hold_cnt", 32'(bus_a.out_cnt), 16);
        end
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b1;
        tick();
        check("bp_released", 32'(bus_a.out_valid), 0);
        bus_a.flush = 1'b1;
        send_a(5'd7);
        bus_a.flush = 1'b0;
        check("bp_next_acc", 32'(bus_a.out_acc), 7);
        check("bp_next_cnt", 32'(bus_a.out_cnt), 1);
        tick();
        $display("txn: back-pressure block then fresh block acc=%0d cnt=%0d", bus_a.out_acc, bus_a.out_cnt);

        // Reset mid-block discards data
        for (int i = 0; i < 6; i++) send_a(5'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_valid", 32'(bus_a.out_valid), 0);
        check("midrst_out_acc", 32'(bus_a.out_acc), 0);
        for (int i = 0; i < 15; i++) send_a(5'd1);
        check("midrst_no_spurious", 32'(bus_a.out_valid), 0);
        send_a(5'd1);
        check("midrst_valid_after", 32'(bus_a.out_valid), 1);
        check("midrst_acc", 32'(bus_a.out_acc), 16);
        check("midrst_cnt", 32'(bus_a.out_cnt), 16);
        tick();
        $display("txn: reset mid-block then 16x1 acc=%0d cnt=%0d", bus_a.out_acc, bus_a.out_cnt);

        // Overflow on the narrow instance: 31+31+31+1 = 94
        send_b(5'd31);
        send_b(5'd31);
        send_b(5'd31);
        check("ovf_no_early_valid", 32'(bus_b.out_valid), 0);
        send_b(5'd1);
        check("ovf_valid", 32'(bus_b.out_valid), 1);
        check("ovf_flag", 32'(bus_b.out_ovf), 1);
        check("ovf_cnt", 32'(bus_b.out_cnt), 4);
`ifdef SUM_ACCUMULATOR_SATURATE_EN
        check("ovf_acc_sat", 32'(bus_b.out_acc), 63);
`else
        check("ovf_acc_wrap", 32'(bus_b.out_acc), 30);
`endif
        tick();
        check("ovf_emitted", 32'(bus_b.out_valid), 0);
        $display("txn: overflow block acc=%0d cnt=%0d ovf=%0d", bus_b.out_acc, bus_b.out_cnt, bus_b.out_ovf);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
